// File: rtl/alu_mul_seq.sv
// Shift-and-add 8x8 unsigned multiply sequencer that borrows the shared ALU via req/gnt.
// Optional macro ALU_MUL_SEQ_SKIP_ZERO_EN: zero operands finish immediately without using the ALU.
module alu_mul_seq #(
  parameter int OPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   mcand,
  input  logic [OPW-1:0]   mplier,
  output logic             busy,
  output logic             done,
  output logic [2*OPW-1:0] product,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [3:0]       alu_op,
  output logic             alu_s3,
  output logic             alu_s4,
  output logic             alu_cin,
  output logic [OPW-1:0]   alu_r0,
  output logic [OPW-1:0]   alu_rn,
  output logic [OPW-1:0]   alu_or2,
  input  logic [OPW-1:0]   alu_out,
  input  logic [3:0]       alu_flags,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHA  = 3'd2,
    S_SHQ  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] OP_ZERO   = 4'h0;
  localparam logic [3:0] OP_A      = 4'h1;
  localparam logic [3:0] OP_SRC_A  = 4'h7;
  localparam logic [3:0] OP_ADD_AB = 4'h8;

  state_t         state_q, state_d;
  logic [OPW-1:0] acc_q, acc_d;
  logic [OPW-1:0] mq_q, mq_d;
  logic [OPW-1:0] mc_q, mc_d;
  logic           c_q, c_d;
  logic           lb_q, lb_d;
  logic [2:0]     cnt_q, cnt_d;

  logic unused_flags;
  assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      mc_q    <= '0;
      c_q     <= 1'b0;
      lb_q    <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mc_q    <= mc_d;
      c_q     <= c_d;
      lb_q    <= lb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mc_d    = mc_q;
    c_d     = c_q;
    lb_d    = lb_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    alu_op  = OP_ZERO;
    alu_s3  = 1'b0;
    alu_s4  = 1'b0;
    alu_cin = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          mq_d    = mplier;
          mc_d    = mcand;
          cnt_d   = 3'd0;
          c_d     = 1'b0;
          lb_d    = 1'b0;
          state_d = S_ADD;
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
          if (mcand == '0 || mplier == '0) begin
            mq_d    = '0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_ADD: begin
        busy   = 1'b1;
        alu_s4 = 1'b1;
        alu_op = mq_q[0] ? OP_ADD_AB : OP_A;
        if (alu_gnt) begin
          acc_d   = alu_out;
          c_d     = alu_flags[1];
          state_d = S_SHA;
        end
      end
      S_SHA: begin
        // Rotate {c,acc} right: carry enters acc[7], acc[0] falls out into lb.
        busy    = 1'b1;
        alu_op  = OP_SRC_A;
        alu_cin = c_q;
        if (alu_gnt) begin
          acc_d   = alu_out;
          lb_d    = alu_flags[1];
          state_d = S_SHQ;
        end
      end
      S_SHQ: begin
        busy    = 1'b1;
        alu_op  = OP_SRC_A;
        alu_s3  = 1'b1;
        alu_cin = lb_q;
        if (alu_gnt) begin
          mq_d    = alu_out;
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? S_DONE : S_ADD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_req   = busy;
  assign alu_r0    = acc_q;
  assign alu_rn    = mq_q;
  assign alu_or2   = mc_q;
  assign product   = {acc_q, mq_q};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU, directed and random multiplies, checked with a*b arithmetic.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  mcand = 8'h00;
  logic [7:0]  mplier = 8'h00;
  logic        busy, done, alu_req;
  logic [15:0] product;
  logic        gnt = 1'b0;
  logic [3:0]  alu_op;
  logic        alu_s3, alu_s4, alu_cin;
  logic [7:0]  alu_r0, alu_rn, alu_or2;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.OPW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .alu_req(alu_req),
    .alu_gnt(gnt), .alu_op(alu_op), .alu_s3(alu_s3), .alu_s4(alu_s4),
    .alu_cin(alu_cin), .alu_r0(alu_r0), .alu_rn(alu_rn), .alu_or2(alu_or2),
    .alu_out(alu_out), .alu_flags(alu_flags), .dbg_state(dbg_state)
  );

  // Behavioural shared ALU: only the opcodes this sequencer uses
  logic [7:0] op_a, op_b;
  logic       cout;
  always_comb begin
    op_a = alu_s3 ? alu_rn : alu_r0;
    op_b = alu_s4 ? alu_or2 : 8'h00;
    alu_out = 8'h00;
    cout = 1'b0;
    case (alu_op)
      4'h1: alu_out = op_a;
      4'h7: begin alu_out = {alu_cin, op_a[7:1]}; cout = op_a[0]; end
      4'h8: {cout, alu_out} = {1'b0, op_a} + {1'b0, op_b} + {8'h00, alu_cin};
      default: alu_out = 8'h00;
    endcase
    alu_flags = {^alu_out, ~alu_out[7], cout, (alu_out == 8'h00)};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gmode: 0 gnt always high, 1 gnt high on even cycles, 2 random gnt
  task automatic run(input logic [7:0] a, input logic [7:0] b, input int gmode,
                     input int exp_lat, input int rp_k, input int rst_k);
    int  g;
    bit  fin;
    int  done_k;
    logic [15:0] exp_p;
    exp_p = 16'(a) * 16'(b);
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1; gnt = 1'b0;
    @(negedge clk);
    start = 1'b0;
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
    g = (a == 8'h00 || b == 8'h00) ? 24 : 0;
`else
    g = 0;
`endif
    fin = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 200; k++) begin
      case (gmode)
        0: gnt = 1'b1;
        1: gnt = (k % 2 == 0);
        default: gnt = 1'($urandom_range(0, 1));
      endcase
      if (k == rp_k) begin
        start = 1'b1; mcand = ~a; mplier = b + 8'd1;
      end else begin
        start = 1'b0;
      end
      if (k == rst_k) rst = 1'b1;
      #1;
      if (g < 24) begin
        check("req_busy", {31'b0, alu_req}, 32'd1);
        check("no_early_done", {31'b0, done}, 32'd0);
        case (g % 3)
          0: check("op_add", {28'b0, alu_op}, b[g/3] ? 32'h8 : 32'h1);
          default: check("op_rot", {28'b0, alu_op}, 32'h7);
        endcase
        check("sel_a", {31'b0, alu_s3}, (g % 3 == 2) ? 32'd1 : 32'd0);
        if (g % 3 == 0) check("sel_b", {31'b0, alu_s4}, 32'd1);
        check("or2_mcand", {24'b0, alu_or2}, {24'b0, a});
        if (gnt) g++;
      end else begin
        check("done_pulse", {31'b0, done}, 32'd1);
        check("done_req_low", {31'b0, alu_req}, 32'd0);
        check("product", {16'b0, product}, {16'b0, exp_p});
        fin = 1'b1;
        done_k = k;
      end
      if (k == rst_k) begin
        @(negedge clk);
        rst = 1'b0; gnt = 1'b1;
        #1;
        check("rst_req", {31'b0, alu_req}, 32'd0);
        check("rst_product", {16'b0, product}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          #1;
          check("rst_no_done", {31'b0, done}, 32'd0);
        end
        return;
      end
      if (fin) break;
      @(negedge clk);
    end
    check("finished", {31'b0, fin}, 32'd1);
    if (exp_lat > 0) check("latency", done_k, exp_lat);
    @(negedge clk);
    gnt = 1'b1;
    #1;
    check("idle_after_done", {30'b0, done, busy}, 32'd0);
    check("product_held", {16'b0, product}, {16'b0, exp_p});
  endtask

  initial begin
    int zlat;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outs", {27'b0, busy, done, alu_req, alu_s3, alu_s4}, 32'd0);
    check("reset_op_cin", {27'b0, alu_op, alu_cin}, 32'd0);
    check("reset_product", {16'b0, product}, 32'd0);

    run(8'd13, 8'd11, 0, 25, 0, 0);
    run(8'hFF, 8'hFF, 0, 25, 0, 0);
    run(8'h80, 8'h03, 1, 49, 0, 0);
    run(8'h5A, 8'hC3, 0, 25, 5, 0);
    run(8'h77, 8'h99, 0, 0, 0, 10);
    run(8'd2, 8'd3, 0, 25, 0, 0);
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
    zlat = 1;
`else
    zlat = 25;
`endif
    run(8'd0, 8'd200, 0, zlat, 0, 0);
    run(8'd37, 8'd0, 0, zlat, 0, 0);
    for (int i = 0; i < 10; i++)
      run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
